// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Candidate classification turns one full scan map into NONE/KEY/GHOST.
package keypad_pkg;

  typedef enum logic {
    KP_IDLE,
    KP_PRESSED
  } kp_state_t;

  typedef enum logic [1:0] {
    CAND_NONE,
    CAND_KEY,
    CAND_GHOST
  } cand_kind_t;

  typedef struct packed {
    cand_kind_t kind;
    logic [3:0] code;
  } cand_t;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  localparam cand_t CAND_RESET = '{
    kind: CAND_NONE,
    code: 4'h0
  };

  // Code is forced to zero unless exactly one key is down,
  // so equal candidates always compare equal bit-for-bit.
  function automatic cand_t classify(
    input logic [KP_KEYS-1:0] map
  );
    cand_t      c;
    logic [4:0] n;
    logic [3:0] idx;
    n   = '0;
    idx = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (map[i]) begin
        n   = n + 5'd1;
        idx = 4'(i);
      end
    end
    c.kind = CAND_NONE;
    c.code = 4'h0;
    if (n == 5'd1) begin
      c.kind = CAND_KEY;
      c.code = idx;
    end else if (n >= 5'd2) begin
      c.kind = CAND_GHOST;
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all-ones so idle pulled-up lines read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages to resolve metastability.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-level debounce.
// Reports one accepted key with press/release pulses.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_MAX  = BW'(DEBOUNCE_SCANS);
  localparam logic [BW-1:0] DEB_ONE  = BW'(1);
  localparam logic [1:0]    ROW_LAST = 2'(KP_ROWS - 1);

  logic [3:0]         col_sync;
  logic [DW-1:0]      div_cnt;
  logic [1:0]         row_idx;
  logic [KP_KEYS-1:0] scan_map;
  logic [KP_KEYS-1:0] map_next;
  logic               tick;
  logic               scan_end;
  cand_t              cand;
  cand_t              prev_cand;
  logic [BW-1:0]      deb_cnt;
  logic [BW-1:0]      deb_next;
  logic               accept;
  kp_state_t          state;
  logic               pend;
  logic [3:0]         pend_code;

  sync_2ff #(
    .W(KP_COLS)
  ) u_sync (
    .clk  (clk),
    .arstn(arstn),
    .d    (col_in),
    .q    (col_sync)
  );

  assign tick     = (div_cnt == DIV_LAST);
  assign scan_end = tick && (row_idx == ROW_LAST);

  // Map as it will look once the current row is sampled,
  // so the last row takes part in this scan's candidate.
  always_comb begin
    map_next = scan_map;
    map_next[{row_idx, 2'b00} +: 4] = ~col_sync;
  end

  assign cand = classify(map_next);

  // Run length of identical non-ghost candidates.
  always_comb begin
    deb_next = deb_cnt;
    if (cand == prev_cand) begin
      if (deb_cnt != DEB_MAX) begin
        deb_next = deb_cnt + DEB_ONE;
      end
    end else begin
      deb_next = DEB_ONE;
    end
  end

  assign accept = scan_end
               && (cand.kind != CAND_GHOST)
               && (deb_next == DEB_MAX);

  // Row divider, strobe rotation, scan map and debounce history.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      div_cnt   <= '0;
      row_idx   <= '0;
      row_drive <= ROW_RESET;
      scan_map  <= '0;
      prev_cand <= CAND_RESET;
      deb_cnt   <= '0;
    end else if (tick) begin
      div_cnt   <= '0;
      row_idx   <= row_idx + 2'd1;
      row_drive <= {row_drive[2:0], row_drive[3]};
      scan_map  <= map_next;
      if (scan_end && cand.kind != CAND_GHOST) begin
        prev_cand <= cand;
        deb_cnt   <= deb_next;
      end
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Press/release FSM; a slide to another key goes through
  // one IDLE clock carrying the release before the new press.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= KP_IDLE;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      pend        <= 1'b0;
      pend_code   <= '0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      unique case (state)
        KP_IDLE: begin
          if (pend) begin
            state     <= KP_PRESSED;
            key_code  <= pend_code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            pend      <= 1'b0;
          end else if (accept && cand.kind == CAND_KEY) begin
            state     <= KP_PRESSED;
            key_code  <= cand.code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end
        end
        KP_PRESSED: begin
          if (accept) begin
            if (cand.kind == CAND_NONE) begin
              state       <= KP_IDLE;
              key_release <= 1'b1;
              key_held    <= 1'b0;
            end else if (cand.code != key_code) begin
              state       <= KP_IDLE;
              key_release <= 1'b1;
              key_held    <= 1'b0;
              pend        <= 1'b1;
              pend_code   <= cand.code;
            end
          end
        end
        default: state <= KP_IDLE;
      endcase
    end
  end

endmodule
